// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared states, instruction codes and terminator for the program loader
package bf_pkg;

  typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_TERM, LD_DONE} ld_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  localparam logic [7:0] CH_INC   = 8'h2B;
  localparam logic [7:0] CH_DEC   = 8'h2D;
  localparam logic [7:0] CH_LEFT  = 8'h3C;
  localparam logic [7:0] CH_RIGHT = 8'h3E;
  localparam logic [7:0] CH_OPEN  = 8'h5B;
  localparam logic [7:0] CH_CLOSE = 8'h5D;
  localparam logic [7:0] CH_OUT   = 8'h2E;
  localparam logic [7:0] CH_IN    = 8'h2C;

  localparam int TERMINATOR = 0;

  function automatic logic is_bf_instr(input logic [31:0] c);
    return (c == 32'(CH_INC))  || (c == 32'(CH_DEC))   ||
           (c == 32'(CH_LEFT)) || (c == 32'(CH_RIGHT)) ||
           (c == 32'(CH_OPEN)) || (c == 32'(CH_CLOSE)) ||
           (c == 32'(CH_OUT))  || (c == 32'(CH_IN));
  endfunction

endpackage

// File: rtl/bf_uart_rx.sv
// rtl/bf_uart_rx.sv - oversampled mid-bit UART receiver with rx synchroniser
// Emits a registered byte-valid or frame-error pulse one cycle after the stop-bit sample.
module bf_uart_rx import bf_pkg::*; #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tick,
  input  logic                 i_rx,
  input  logic                 i_clear,
  output logic [DATA_BITS-1:0] o_byte,
  output logic                 o_valid,
  output logic                 o_frameErr
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  rx_state_e              r_state, w_stateNext;
  logic [CW-1:0]          r_tickCnt, w_tickCntNext;
  logic [BW-1:0]          r_bitCnt, w_bitCntNext;
  logic [DATA_BITS-1:0]   r_shift, w_shiftNext;
  logic                   w_rxS, w_valid, w_frameErr;

  assign w_rxS  = r_sync[SYNC_STAGES-1];
  assign o_byte = r_shift;

  always_comb begin
    w_stateNext   = r_state;
    w_tickCntNext = r_tickCnt;
    w_bitCntNext  = r_bitCnt;
    w_shiftNext   = r_shift;
    w_valid       = 1'b0;
    w_frameErr    = 1'b0;
    if (i_clear) begin
      w_stateNext   = RX_IDLE;
      w_tickCntNext = '0;
      w_bitCntNext  = '0;
    end else if (i_tick) begin
      case (r_state)
        RX_IDLE: begin
          if (!w_rxS) begin
            w_stateNext   = RX_START;
            w_tickCntNext = '0;
          end
        end
        RX_START: begin
          // Half a bit in: a line that is high again was only a glitch.
          if (r_tickCnt == CW'(OVERSAMPLE/2 - 1)) begin
            w_tickCntNext = '0;
            w_bitCntNext  = '0;
            w_stateNext   = w_rxS ? RX_IDLE : RX_DATA;
          end else begin
            w_tickCntNext = r_tickCnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_tickCnt == CW'(OVERSAMPLE - 1)) begin
            w_tickCntNext = '0;
            w_shiftNext   = {w_rxS, r_shift[DATA_BITS-1:1]};
            if (r_bitCnt == BW'(DATA_BITS - 1)) w_stateNext = RX_STOP;
            else                                w_bitCntNext = r_bitCnt + 1'b1;
          end else begin
            w_tickCntNext = r_tickCnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_tickCnt == CW'(OVERSAMPLE - 1)) begin
            w_tickCntNext = '0;
            w_stateNext   = RX_IDLE;
            w_valid       = w_rxS;
            w_frameErr    = !w_rxS;
          end else begin
            w_tickCntNext = r_tickCnt + 1'b1;
          end
        end
        default: w_stateNext = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync     <= '1;
      r_state    <= RX_IDLE;
      r_tickCnt  <= '0;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      o_valid    <= 1'b0;
      o_frameErr <= 1'b0;
    end else begin
      r_sync[0] <= i_rx;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_state    <= w_stateNext;
      r_tickCnt  <= w_tickCntNext;
      r_bitCnt   <= w_bitCntNext;
      r_shift    <= w_shiftNext;
      o_valid    <= w_valid;
      o_frameErr <= w_frameErr;
    end
  end

endmodule

// File: rtl/bf_program_loader.sv
// rtl/bf_program_loader.sv - UART program loader writing bytes into program memory
// BF_LOADER_FILTER_EN: when defined, only the eight instruction codes are stored.
module bf_program_loader import bf_pkg::*; #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_sysClk,
  input  logic                  i_reset,
  input  logic                  i_uartTick,
  input  logic                  i_loading,
  input  logic                  i_rx,
  output logic                  o_memWe,
  output logic [ADDR_WIDTH-1:0] o_memAddr,
  output logic [DATA_BITS-1:0]  o_memData,
  output logic [ADDR_WIDTH:0]   o_progLen,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic                  o_frameErr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  ld_state_e             r_state, w_stateNext;
  logic [ADDR_WIDTH-1:0] r_wrPtr;
  logic                  r_overflow, r_frameErr, r_done;
  logic [DATA_BITS-1:0]  w_rxByte;
  logic                  w_rxValid, w_rxFrameErr, w_clear, w_keep;
  logic                  w_accept, w_write, w_drop, w_enterLoad;

  bf_uart_rx #(
    .DATA_BITS   (DATA_BITS),
    .OVERSAMPLE  (OVERSAMPLE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .i_clk      (i_sysClk),
    .i_rst      (i_reset),
    .i_tick     (i_uartTick),
    .i_rx       (i_rx),
    .i_clear    (w_clear),
    .o_byte     (w_rxByte),
    .o_valid    (w_rxValid),
    .o_frameErr (w_rxFrameErr)
  );

  assign w_clear = (r_state != LD_LOAD);

`ifdef BF_LOADER_FILTER_EN
  assign w_keep = is_bf_instr(32'(w_rxByte));
`else
  assign w_keep = 1'b1;
`endif

  // A byte landing in the cycle loading falls is discarded in favour of the terminator.
  assign w_accept    = (r_state == LD_LOAD) && i_loading && w_rxValid && w_keep;
  assign w_write     = w_accept && (r_wrPtr != LAST_ADDR);
  assign w_drop      = w_accept && (r_wrPtr == LAST_ADDR);
  assign w_enterLoad = (w_stateNext == LD_LOAD) && (r_state != LD_LOAD);

  always_comb begin
    w_stateNext = r_state;
    o_memWe     = 1'b0;
    o_memData   = '0;
    case (r_state)
      LD_IDLE: if (i_loading) w_stateNext = LD_LOAD;
      LD_LOAD: begin
        if (!i_loading) w_stateNext = LD_TERM;
        o_memWe   = w_write;
        o_memData = w_write ? w_rxByte : '0;
      end
      LD_TERM: begin
        w_stateNext = LD_DONE;
        o_memWe     = 1'b1;
        o_memData   = DATA_BITS'(TERMINATOR);
      end
      LD_DONE: if (i_loading) w_stateNext = LD_LOAD;
      default: w_stateNext = LD_IDLE;
    endcase
  end

  always_ff @(posedge i_sysClk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= LD_IDLE;
      r_wrPtr    <= '0;
      r_overflow <= 1'b0;
      r_frameErr <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_done  <= (r_state == LD_TERM);
      if (w_enterLoad) begin
        r_wrPtr    <= '0;
        r_overflow <= 1'b0;
        r_frameErr <= 1'b0;
      end else begin
        if (w_write) r_wrPtr <= r_wrPtr + 1'b1;
        if (w_drop) r_overflow <= 1'b1;
        if ((r_state == LD_LOAD) && i_loading && w_rxFrameErr) r_frameErr <= 1'b1;
      end
    end
  end

  assign o_memAddr  = r_wrPtr;
  assign o_progLen  = {1'b0, r_wrPtr};
  assign o_busy     = (r_state == LD_LOAD) || (r_state == LD_TERM);
  assign o_done     = r_done;
  assign o_overflow = r_overflow;
  assign o_frameErr = r_frameErr;

endmodule

// File: tb/tb_bf_program_loader.sv
// tb/tb_bf_program_loader.sv - scoreboard bench for bf_program_loader (16x oversampling)
module tb_bf_program_loader;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  typedef struct {
    int inst;
    int kind;
    int addr;
    int data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] tick_div = 2'd0;
  logic       tick;

  logic       a_ld, a_rx, a_we, a_busy, a_done, a_ovf, a_fe;
  logic [3:0] a_addr;
  logic [7:0] a_data;
  logic [4:0] a_len;

  logic       b_ld, b_rx, b_we, b_busy, b_done, b_ovf, b_fe;
  logic [1:0] b_addr;
  logic [7:0] b_data;
  logic [2:0] b_len;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  logic [7:0] prog1 [5] = '{8'h2B, 8'h5B, 8'h2E, 8'h2B, 8'h5D};
  logic [7:0] prog2 [4] = '{8'h2B, 8'h61, 8'h0A, 8'h2E};

  always #5 clk = ~clk;
  always @(posedge clk) tick_div <= tick_div + 2'd1;
  assign tick = (tick_div == 2'd0);

  bf_program_loader #(.DATA_BITS(8), .OVERSAMPLE(16), .ADDR_WIDTH(4), .SYNC_STAGES(2)) dut_a (
    .i_sysClk(clk), .i_reset(reset), .i_uartTick(tick), .i_loading(a_ld), .i_rx(a_rx),
    .o_memWe(a_we), .o_memAddr(a_addr), .o_memData(a_data), .o_progLen(a_len),
    .o_busy(a_busy), .o_done(a_done), .o_overflow(a_ovf), .o_frameErr(a_fe)
  );

  bf_program_loader #(.DATA_BITS(8), .OVERSAMPLE(16), .ADDR_WIDTH(2), .SYNC_STAGES(2)) dut_b (
    .i_sysClk(clk), .i_reset(reset), .i_uartTick(tick), .i_loading(b_ld), .i_rx(b_rx),
    .o_memWe(b_we), .o_memAddr(b_addr), .o_memData(b_data), .o_progLen(b_len),
    .o_busy(b_busy), .o_done(b_done), .o_overflow(b_ovf), .o_frameErr(b_fe)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic mon(input int inst, input logic we, input int addr, input int data,
                     input logic dn, input int len);
    ev_t e;
    if (we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected inst=%0d got addr=%0d data=%0h expected no write", inst, addr, data);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != 0 || e.inst != inst || e.addr != addr || e.data != data) begin
          bad++;
          $display("FAIL write inst=%0d got addr=%0d data=%0h expected inst=%0d kind=%0d addr=%0d data=%0h",
                   inst, addr, data, e.inst, e.kind, e.addr, e.data);
        end
      end
    end
    if (dn) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected inst=%0d got progLen=%0d expected no done", inst, len);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != 1 || e.inst != inst || e.data != len) begin
          bad++;
          $display("FAIL done inst=%0d got progLen=%0d expected inst=%0d kind=%0d progLen=%0d",
                   inst, len, e.inst, e.kind, e.data);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, a_we, int'(a_addr), int'(a_data), a_done, int'(a_len));
    mon(1, b_we, int'(b_addr), int'(b_data), b_done, int'(b_len));
  end

  function automatic int get_we(input int inst);   return inst == 0 ? int'(a_we)   : int'(b_we);   endfunction
  function automatic int get_done(input int inst); return inst == 0 ? int'(a_done) : int'(b_done); endfunction
  function automatic int get_len(input int inst);  return inst == 0 ? int'(a_len)  : int'(b_len);  endfunction
  function automatic int get_busy(input int inst); return inst == 0 ? int'(a_busy) : int'(b_busy); endfunction

  task automatic set_rx(input int inst, input logic v);
    if (inst == 0) a_rx = v; else b_rx = v;
  endtask

  task automatic set_load(input int inst, input logic v);
    @(negedge clk);
    if (inst == 0) a_ld = v; else b_ld = v;
  endtask

  task automatic expect_wr(input int inst, input int addr, input int data);
    ev_t e;
    e.inst = inst; e.kind = 0; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic expect_done(input int inst, input int len);
    ev_t e;
    e.inst = inst; e.kind = 1; e.addr = 0; e.data = len;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input int inst, input logic [7:0] d, input logic stop);
    @(negedge clk);
    set_rx(inst, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(inst, d[i]);
      repeat (BIT_CLKS) @(negedge clk);
    end
    set_rx(inst, stop);
    repeat (BIT_CLKS) @(negedge clk);
    set_rx(inst, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got pending=%0d expected pending=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic end_load(input int inst, input int term_addr, input int len);
    expect_wr(inst, term_addr, 0);
    expect_done(inst, len);
    set_load(inst, 1'b0);
    @(posedge clk); #1;
    check("term_timing", get_we(inst), 1);
    @(posedge clk); #1;
    check("done_timing", get_done(inst), 1);
    wait_drain();
    @(negedge clk);
    check("proglen_frozen", get_len(inst), len);
    check("busy_after_done", get_busy(inst), 0);
  endtask

  task automatic check_reset_a(input string name);
    check(name, int'({a_we, a_addr, a_data, a_len, a_busy, a_done, a_ovf, a_fe}), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_rx = 1'b1; b_rx = 1'b1;
    a_ld = 1'b0; b_ld = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_a("reset_outputs");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_busy", int'(a_busy), 0);

    // program "+[.+]"
    set_load(0, 1'b1);
    repeat (4) @(negedge clk);
    check("load_busy", int'(a_busy), 1);
    for (int i = 0; i < 5; i++) expect_wr(0, i, int'(prog1[i]));
    for (int i = 0; i < 5; i++) send_byte(0, prog1[i], 1'b1);
    check("live_proglen", int'(a_len), 5);
    end_load(0, 5, 5);

    // instruction filter
    set_load(0, 1'b1);
    repeat (4) @(negedge clk);
    check("reload_proglen_cleared", int'(a_len), 0);
`ifdef BF_LOADER_FILTER_EN
    expect_wr(0, 0, 8'h2B);
    expect_wr(0, 1, 8'h2E);
    for (int i = 0; i < 4; i++) send_byte(0, prog2[i], 1'b1);
    check("filter_no_overflow", int'(a_ovf), 0);
    end_load(0, 2, 2);
`else
    for (int i = 0; i < 4; i++) expect_wr(0, i, int'(prog2[i]));
    for (int i = 0; i < 4; i++) send_byte(0, prog2[i], 1'b1);
    check("nofilter_no_overflow", int'(a_ovf), 0);
    end_load(0, 4, 4);
`endif

    // stop bit low, then a good byte
    set_load(0, 1'b1);
    repeat (4) @(negedge clk);
    send_byte(0, 8'h2B, 1'b0);
    check("frame_err_set", int'(a_fe), 1);
    check("frame_err_no_write", int'(a_len), 0);
    expect_wr(0, 0, 8'h2D);
    send_byte(0, 8'h2D, 1'b1);
    check("frame_err_sticky", int'(a_fe), 1);
    end_load(0, 1, 1);

    // 3-tick glitch on rx
    set_load(0, 1'b1);
    repeat (4) @(negedge clk);
    check("frame_err_cleared", int'(a_fe), 0);
    set_rx(0, 1'b0);
    repeat (3 * TICK_DIV) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (12 * BIT_CLKS) @(negedge clk);
    check("glitch_no_frame_err", int'(a_fe), 0);
    check("glitch_no_write", int'(a_len), 0);
    end_load(0, 0, 0);

    // overflow on the 4-entry memory
    set_load(1, 1'b1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) expect_wr(1, i, 8'h2B);
    for (int i = 0; i < 3; i++) send_byte(1, 8'h2B, 1'b1);
    check("full_no_overflow_yet", int'(b_ovf), 0);
    for (int i = 0; i < 2; i++) send_byte(1, 8'h2B, 1'b1);
    check("overflow_set", int'(b_ovf), 1);
    end_load(1, 3, 3);
    check("overflow_sticky_done", int'(b_ovf), 1);

    // reset in the middle of a byte while loading
    set_load(0, 1'b1);
    repeat (4) @(negedge clk);
    set_rx(0, 1'b0);
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("busy_before_reset", int'(a_busy), 1);
    reset = 1'b1;
    #1;
    check_reset_a("reset_mid_byte");
    set_rx(0, 1'b1);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4 * BIT_CLKS) @(negedge clk);
    expect_wr(0, 0, 8'h3E);
    send_byte(0, 8'h3E, 1'b1);
    end_load(0, 1, 1);

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
